// File: rtl/instruction_ram_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : instr_ram_pkg
//  Description : Shared types and default sizing for instruction_ram_seq.
//                mode_e encodes the replay/load mode presented on the
//                instruction RAM bus. The optional breakpoint feature of the
//                top level is enabled with INSTR_RAM_BREAKPOINT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_ram_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,   // free-running replay
    WRITE = 2'd1,   // byte-serial program load
    STEP  = 2'd2,   // one instruction per debug-button press
    RAND  = 2'd3    // random access by instruction index
  } mode_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_INSTR_BYTES = 2;

  // Width of an instruction index for a RAM of depth bytes.
  function automatic int instr_addr_w(input int depth, input int instr_bytes);
    return $clog2(depth / instr_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_ram_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface   : instruction_ram_seq_if
//  Description : Load/replay bus of instruction_ram_seq.
//                master : drives mode, step, address, data_in, bp_addr
//                slave  : drives instr_out, pc, prog_len, at_end, overflow,
//                         bp_hit
//                bp_addr/bp_hit only matter when the RAM is built with
//                INSTR_RAM_BREAKPOINT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
interface instruction_ram_seq_if #(
  parameter int DATA_W      = 8,
  parameter int INSTR_BYTES = 2,
  parameter int ADDR_W      = 7
);
  logic [1:0]                    mode;
  logic                          step;
  logic [ADDR_W-1:0]             address;
  logic [DATA_W-1:0]             data_in;
  logic [ADDR_W-1:0]             bp_addr;
  logic [INSTR_BYTES*DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0]             pc;
  logic [ADDR_W:0]               prog_len;
  logic                          at_end;
  logic                          overflow;
  logic                          bp_hit;

  modport master (
    output mode, step, address, data_in, bp_addr,
    input  instr_out, pc, prog_len, at_end, overflow, bp_hit
  );

  modport slave (
    input  mode, step, address, data_in, bp_addr,
    output instr_out, pc, prog_len, at_end, overflow, bp_hit
  );
endinterface
`default_nettype wire

// File: rtl/instruction_ram_seq_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : One-register rising-edge detector.
//                clk    in  system clock
//                rst    in  synchronous reset, active-low
//                d_i    in  level input
//                rise_o out high in the cycle d_i is 1 and was 0 last clk
//  Revision    : 1.0  initial release
// ============================================================================
module rise_detect (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d_i,
  output logic      rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule
`default_nettype wire

// File: rtl/instruction_ram_seq.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_ram_seq
//  Description : Byte-loaded instruction RAM replayed as INSTR_BYTES-wide
//                words. Modes: READ (run), WRITE (load), STEP (debug button),
//                RAND (random access). Tracks program length, flags overflow
//                and end of program.
//                clk  in  system clock
//                rst  in  synchronous reset, active-low
//                bus  slave modport of instruction_ram_seq_if
//  Options     : INSTR_RAM_BREAKPOINT_EN - halt READ at bus.bp_addr and
//                report bus.bp_hit; a step rise resumes.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_ram_seq
  import instr_ram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int ADDR_W      = instr_addr_w(DEPTH, INSTR_BYTES)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  instruction_ram_seq_if.slave  bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;       // must be able to hold DEPTH
  localparam int LEN_W  = ADDR_W + 1;
  localparam int WORD_W = INSTR_BYTES * DATA_W;

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic              overflow_q, overflow_d;
  mode_e             mode_q;
  logic [WORD_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              at_end_q;
  logic              bp_hit_q,   bp_hit_d;

  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  mode_e             w_mode;
  logic              w_entry;
  logic              w_rise;
  logic [LEN_W-1:0]  w_prog_len;
  logic [LEN_W-1:0]  w_last;
  logic              w_can_adv;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_word;

  assign w_mode  = mode_e'(bus.mode);
  assign w_entry = (w_mode != mode_q);

  rise_detect u_step_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.step),
    .rise_o (w_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst) mode_q <= READ;
    else      mode_q <= w_mode;
  end

  // Only complete instructions count; a trailing partial word is ignored.
  assign w_prog_len = LEN_W'(wr_ptr_q / PTR_W'(INSTR_BYTES));
  assign w_last     = w_prog_len - LEN_W'(1);

  // --------------------------------------------------------------------
  // Load path
  // --------------------------------------------------------------------
  always_comb begin
    w_we       = 1'b0;
    w_waddr    = '0;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (w_mode == WRITE) begin
      if (w_entry) begin
        // A fresh load starts a new program at byte 0.
        w_we       = 1'b1;
        w_waddr    = '0;
        wr_ptr_d   = PTR_W'(1);
        overflow_d = 1'b0;
      end else if (wr_ptr_q == PTR_W'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        w_we     = 1'b1;
        w_waddr  = wr_ptr_q[IDX_W-1:0];
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Contents survive reset; prog_len=0 keeps stale bytes from being shown.
  always_ff @(posedge clk) begin
    if (rst && w_we) mem_q[w_waddr] <= bus.data_in;
  end

  // --------------------------------------------------------------------
  // Next instruction index
  // --------------------------------------------------------------------
  // pc never exceeds last while a program is present (leaving WRITE always
  // restarts at 0), so min(pc+1, last) reduces to a single compare.
  assign w_can_adv = ((LEN_W'(pc_q) + LEN_W'(1)) < w_prog_len);
  assign w_inc     = w_can_adv ? (pc_q + ADDR_W'(1)) : pc_q;

  always_comb begin
    w_pc_next = pc_q;
    bp_hit_d  = bp_hit_q;
    if (w_entry) bp_hit_d = 1'b0;
    case (w_mode)
      READ: begin
        if (w_entry) begin
          w_pc_next = '0;
        end else begin
          w_pc_next = w_inc;
`ifdef INSTR_RAM_BREAKPOINT_EN
          if (bp_hit_q) begin
            // Halted: a step rise releases one instruction and resumes.
            if (w_rise) begin
              w_pc_next = w_inc;
              bp_hit_d  = 1'b0;
            end else begin
              w_pc_next = pc_q;
            end
          end else if (w_can_adv && (pc_q == bus.bp_addr)) begin
            w_pc_next = pc_q;
            bp_hit_d  = 1'b1;
          end
`endif
        end
      end
      STEP: begin
        if (w_entry)     w_pc_next = '0;
        else if (w_rise) w_pc_next = w_inc;
        else             w_pc_next = pc_q;
      end
      RAND: begin
        if (LEN_W'(bus.address) > w_last) w_pc_next = w_last[ADDR_W-1:0];
        else                              w_pc_next = bus.address;
      end
      default: w_pc_next = pc_q;
    endcase
`ifndef INSTR_RAM_BREAKPOINT_EN
    bp_hit_d = 1'b0;
`endif
  end

`ifndef INSTR_RAM_BREAKPOINT_EN
  logic w_unused_bp;
  assign w_unused_bp = ^bus.bp_addr;
`endif

  // --------------------------------------------------------------------
  // Read taps: one combinational tap per byte of the next instruction
  // --------------------------------------------------------------------
  for (genvar b = 0; b < INSTR_BYTES; b++) begin : g_tap
    assign w_word[b*DATA_W +: DATA_W] =
      mem_q[IDX_W'(int'(w_pc_next) * INSTR_BYTES + b)];
  end

  // --------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q  <= '0;
      pc_q     <= '0;
      at_end_q <= 1'b1;
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
      if (w_mode != WRITE) begin
        if (w_prog_len == '0) begin
          instr_q  <= '0;
          pc_q     <= '0;
          at_end_q <= 1'b1;
        end else begin
          instr_q  <= w_word;
          pc_q     <= w_pc_next;
          at_end_q <= (LEN_W'(w_pc_next) == w_last);
        end
      end
    end
  end

  assign bus.instr_out = instr_q;
  assign bus.pc        = pc_q;
  assign bus.prog_len  = w_prog_len;
  assign bus.at_end    = at_end_q;
  assign bus.overflow  = overflow_q;
  assign bus.bp_hit    = bp_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_ram_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_ram_seq
//  Description : Scoreboard bench for instruction_ram_seq (DEPTH=16,
//                INSTR_BYTES=2). A byte-array program model predicts the
//                outputs of every clock; a monitor compares after each edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_ram_seq;
  import instr_ram_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IB     = 2;
  localparam int ADDR_W = $clog2(DEPTH / IB);
  localparam int WORD_W = IB * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_ram_seq_if #(.DATA_W(DATA_W), .INSTR_BYTES(IB), .ADDR_W(ADDR_W)) bus ();

  instruction_ram_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .INSTR_BYTES(IB), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WORD_W-1:0] instr;
    int                pc;
    int                plen;
    bit                at_end;
    bit                ovf;
    bit                bp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the program as a byte array plus a byte count.
  logic [7:0]        m_mem[DEPTH];
  int                m_wr = 0, m_pc = 0, m_pmode = 0;
  logic [WORD_W-1:0] m_instr = '0;
  bit                m_ovf = 0, m_at_end = 1, m_bp = 0, m_pstep = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WORD_W-1:0] word_at(input int idx);
    logic [WORD_W-1:0] w = '0;
    for (int b = 0; b < IB; b++) w |= WORD_W'(m_mem[idx*IB + b]) << (8*b);
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input int md, input bit st, input int adr,
                       input logic [7:0] din, input int bpa);
    bit entry, rise;
    int plen, last, nxt;
    if (!r) begin
      m_pc = 0; m_instr = '0; m_wr = 0; m_ovf = 0; m_at_end = 1; m_bp = 0;
      m_pmode = 0; m_pstep = 0;
      return;
    end
    entry = (md != m_pmode);
    rise  = st && !m_pstep;
    if (entry) m_bp = 0;
    if (md == 1) begin
      if (entry) begin
        m_mem[0] = din; m_wr = 1; m_ovf = 0;
      end else if (m_wr == DEPTH) begin
        m_ovf = 1;
      end else begin
        m_mem[m_wr] = din; m_wr++;
      end
    end else begin
      plen = m_wr / IB;
      last = plen - 1;
      if (md == 3)         nxt = (adr > last) ? last : adr;
      else if (entry)      nxt = 0;
      else if (md == 2)    nxt = rise ? imin(m_pc + 1, last) : m_pc;
      else begin
`ifdef INSTR_RAM_BREAKPOINT_EN
        if (m_bp) begin
          if (rise) begin nxt = imin(m_pc + 1, last); m_bp = 0; end
          else nxt = m_pc;
        end else begin
          nxt = imin(m_pc + 1, last);
          if (m_pc == bpa && nxt > m_pc) begin nxt = m_pc; m_bp = 1; end
        end
`else
        nxt = imin(m_pc + 1, last);
`endif
      end
      if (plen == 0) begin
        m_pc = 0; m_instr = '0; m_at_end = 1;
      end else begin
        m_pc = nxt; m_instr = word_at(nxt); m_at_end = (nxt == last);
      end
    end
    m_pmode = md;
    m_pstep = st;
  endtask

  // One clock of stimulus: drive on the falling edge, predict, enqueue.
  task automatic drive(input bit r, input int md, input bit st, input int adr,
                       input int din, input int bpa);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.mode    = 2'(md);
    bus.step    = st;
    bus.address = ADDR_W'(adr);
    bus.data_in = 8'(din);
    bus.bp_addr = ADDR_W'(bpa);
    model(r, md, st, adr, 8'(din), bpa);
    e.instr  = m_instr;
    e.pc     = m_pc;
    e.plen   = m_wr / IB;
    e.at_end = m_at_end;
    e.ovf    = m_ovf;
    e.bp     = m_bp;
    sb_q.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh output after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("instr_out", 32'(bus.instr_out), 32'(e.instr));
      check("pc",        32'(bus.pc),        32'(e.pc));
      check("prog_len",  32'(bus.prog_len),  32'(e.plen));
      check("at_end",    32'(bus.at_end),    32'(e.at_end));
      check("overflow",  32'(bus.overflow),  32'(e.ovf));
      check("bp_hit",    32'(bus.bp_hit),    32'(e.bp));
    end
  end

  task automatic load(input int n, input int first_byte_seed);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0, (first_byte_seed + i * 37) & 8'hFF, 7);
  endtask

  logic [7:0] prog[8] = '{8'h4A, 8'h24, 8'h4B, 8'h24, 8'h4C, 8'h24, 8'h4D, 8'h24};

  initial begin
    int run_left, md;
    bus.mode = 2'd0; bus.step = 1'b0; bus.address = '0;
    bus.data_in = '0; bus.bp_addr = '0;

    // Reset
    drive(0, 0, 0, 0, 0, 7);
    drive(0, 1, 0, 0, 0, 7);
    drive(1, 0, 0, 0, 0, 7);

    // Load four instructions and run past the end
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, prog[i], 7);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 7);

    // Step: entry, one long press, then six short presses
    drive(1, 2, 0, 0, 0, 7);
    for (int i = 0; i < 3; i++) drive(1, 2, 1, 0, 0, 7);
    for (int i = 0; i < 6; i++) begin
      drive(1, 2, 0, 0, 0, 7);
      drive(1, 2, 1, 0, 0, 7);
    end
    // Entry and rise on the same edge
    drive(1, 0, 0, 0, 0, 7);
    drive(1, 2, 1, 0, 0, 7);

    // Random access, in range and clamped; a step rise is ignored
    drive(1, 3, 0, 2, 0, 7);
    drive(1, 3, 1, 7, 0, 7);
    drive(1, 3, 0, 0, 0, 7);

    // Odd trailing byte does not count
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, prog[i], 7);
    drive(1, 1, 0, 0, 8'h55, 7);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 7);

    // Overflow, then readback, then re-entering WRITE clears it
    load(DEPTH + 2, 8'h11);
    for (int i = 0; i < DEPTH/IB + 2; i++) drive(1, 0, 0, 0, 0, 7);
    drive(1, 1, 0, 0, 8'hA5, 7);
    drive(1, 1, 0, 0, 8'h5A, 7);

    // Reset mid-load discards the program length
    load(4, 8'h33);
    drive(0, 1, 0, 0, 8'h77, 7);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 7);

    // Breakpoint at instruction 1, then a step rise resumes
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, prog[i], 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 1);

    // Randomised runs of modes
    run_left = 0;
    md = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        md = $urandom_range(0, 3);
        run_left = (md == 1) ? $urandom_range(1, DEPTH + 3) : $urandom_range(1, 15);
      end
      run_left--;
      drive(($urandom_range(0, 99) != 0), md, 1'($urandom_range(0, 1)),
            $urandom_range(0, (1 << ADDR_W) - 1), $urandom_range(0, 255),
            $urandom_range(0, (1 << ADDR_W) - 1));
    end

    // Drain the scoreboard within a bounded number of clocks
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
